mem_port_arbiter: RTL and testbench

//   Shares the single sys memory port (req/wr/addr/dout/din/rdy) among N_REQ requesters.

---
 rtl/mem_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one registered memory port among N_REQ requesters,
// with a per-requester lock for atomic read-modify-write and a sticky watchdog.
module mem_port_arbiter #(
    parameter int N_REQ = 4,
    parameter int AW    = 64,
    parameter int DW    = 64,
    parameter int TMO_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    cl_req,
    input  logic [N_REQ-1:0]    cl_wr,
    input  logic [N_REQ-1:0]    cl_lock,
    input  logic [N_REQ*AW-1:0] cl_addr,
    input  logic [N_REQ*DW-1:0] cl_wdata,
    output logic [N_REQ-1:0]    cl_rdy,
    output logic [DW-1:0]       cl_rdata,
    output logic                mem_req,
    output logic                mem_wr,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_dout,
    input  logic [DW-1:0]       mem_din,
    input  logic                mem_rdy,
    output logic                tmo_err
);
    localparam int PW = $clog2(N_REQ);
    localparam logic [TMO_W-1:0] WD_MAX = '1;
    localparam logic [TMO_W-1:0] WD_ONE = 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t            state_reg, state_next;
    logic [PW-1:0]     ptr_reg, ptr_next;
    logic [PW-1:0]     gnt_reg, gnt_next;
    logic [PW-1:0]     lock_own_reg, lock_own_next;
    logic              lock_valid_reg, lock_valid_next;
    logic              lock_req_reg, lock_req_next;
    logic              mem_req_reg, mem_req_next;
    logic              mem_wr_reg, mem_wr_next;
    logic [AW-1:0]     mem_addr_reg, mem_addr_next;
    logic [DW-1:0]     mem_dout_reg, mem_dout_next;
    logic [N_REQ-1:0]  cl_rdy_reg, cl_rdy_next;
    logic [DW-1:0]     cl_rdata_reg, cl_rdata_next;
    logic [TMO_W-1:0]  wd_reg, wd_next;
    logic              tmo_reg, tmo_next;

    logic [AW-1:0]     addr_arr  [N_REQ];
    logic [DW-1:0]     wdata_arr [N_REQ];
    logic [N_REQ-1:0]  elig;
    logic [N_REQ-1:0]  req_elig;
    logic [PW-1:0]     cand;
    logic [PW-1:0]     gnt_idx;
    logic              gnt_any;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = cl_addr[gi*AW +: AW];
            assign wdata_arr[gi] = cl_wdata[gi*DW +: DW];
        end
    endgenerate

    // Scan downward so the last hit is the nearest requester after ptr.
    always_comb begin
        elig = '1;
        if (lock_valid_reg) begin
            elig = '0;
            elig[lock_own_reg] = 1'b1;
        end
        req_elig = cl_req & elig;
        gnt_any  = |req_elig;
        gnt_idx  = ptr_reg;
        cand     = ptr_reg;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = PW'((int'(ptr_reg) + k) % N_REQ);
            if (req_elig[cand]) gnt_idx = cand;
        end
    end

    always_comb begin
        state_next      = state_reg;
        ptr_next        = ptr_reg;
        gnt_next        = gnt_reg;
        lock_own_next   = lock_own_reg;
        lock_valid_next = lock_valid_reg;
        lock_req_next   = lock_req_reg;
        mem_req_next    = mem_req_reg;
        mem_wr_next     = mem_wr_reg;
        mem_addr_next   = mem_addr_reg;
        mem_dout_next   = mem_dout_reg;
        cl_rdy_next     = cl_rdy_reg;
        cl_rdata_next   = cl_rdata_reg;
        wd_next         = wd_reg;
        tmo_next        = tmo_reg;
        case (state_reg)
            IDLE: begin
                if (gnt_any) begin
                    mem_req_next  = 1'b1;
                    mem_wr_next   = cl_wr[gnt_idx];
                    mem_addr_next = addr_arr[gnt_idx];
                    mem_dout_next = wdata_arr[gnt_idx];
                    lock_req_next = cl_lock[gnt_idx];
                    gnt_next      = gnt_idx;
                    ptr_next      = gnt_idx;
                    wd_next       = '0;
                    state_next    = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_rdy) begin
                    mem_req_next = 1'b0;
                    if (!mem_wr_reg) cl_rdata_next = mem_din;
                    cl_rdy_next = '0;
                    cl_rdy_next[gnt_reg] = 1'b1;
                    // Lock ownership follows the lock bit of the op just completed.
                    lock_valid_next = lock_req_reg;
                    lock_own_next   = gnt_reg;
                    wd_next    = '0;
                    state_next = DONE;
                end else if (wd_reg != WD_MAX) begin
                    wd_next = wd_reg + WD_ONE;
                    if (wd_next == WD_MAX) tmo_next = 1'b1;
                end
            end
            DONE: begin
                cl_rdy_next = '0;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            ptr_reg        <= PW'(N_REQ - 1);
            gnt_reg        <= '0;
            lock_own_reg   <= '0;
            lock_valid_reg <= 1'b0;
            lock_req_reg   <= 1'b0;
            mem_req_reg    <= 1'b0;
            mem_wr_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_dout_reg   <= '0;
            cl_rdy_reg     <= '0;
            cl_rdata_reg   <= '0;
            wd_reg         <= '0;
            tmo_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ptr_reg        <= ptr_next;
            gnt_reg        <= gnt_next;
            lock_own_reg   <= lock_own_next;
            lock_valid_reg <= lock_valid_next;
            lock_req_reg   <= lock_req_next;
            mem_req_reg    <= mem_req_next;
            mem_wr_reg     <= mem_wr_next;
            mem_addr_reg   <= mem_addr_next;
            mem_dout_reg   <= mem_dout_next;
            cl_rdy_reg     <= cl_rdy_next;
            cl_rdata_reg   <= cl_rdata_next;
            wd_reg         <= wd_next;
            tmo_reg        <= tmo_next;
        end
    end

    assign mem_req  = mem_req_reg;
    assign mem_wr   = mem_wr_reg;
    assign mem_addr = mem_addr_reg;
    assign mem_dout = mem_dout_reg;
    assign cl_rdy   = cl_rdy_reg;
    assign cl_rdata = cl_rdata_reg;
    assign tmo_err  = tmo_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requester scenarios push expected
// memory ops and completions; a negedge monitor pops and compares them.
module tb_mem_port_arbiter;
    localparam int N  = 4;
    localparam int AW = 64;
    localparam int DW = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    cl_req, cl_wr, cl_lock;
    logic [N*AW-1:0] cl_addr;
    logic [N*DW-1:0] cl_wdata;
    logic [N-1:0]    cl_rdy;
    logic [DW-1:0]   cl_rdata;
    logic            mem_req, mem_wr;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_dout;
    logic [DW-1:0]   mem_din;
    logic            mem_rdy;
    logic            tmo_err;

    mem_port_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .TMO_W(4)) dut (
        .clk(clk), .rst(rst),
        .cl_req(cl_req), .cl_wr(cl_wr), .cl_lock(cl_lock),
        .cl_addr(cl_addr), .cl_wdata(cl_wdata),
        .cl_rdy(cl_rdy), .cl_rdata(cl_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_dout(mem_dout),
        .mem_din(mem_din), .mem_rdy(mem_rdy), .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] addr; logic wr; logic [63:0] dout; } mem_exp_t;
    typedef struct { logic [N-1:0] rdy; logic [63:0] rdata; } cpl_exp_t;
    mem_exp_t mem_q[$];
    cpl_exp_t cpl_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int mem_lat  = 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] val);
        n_checks++;
        n_fail++;
        $display("FAIL %s: value 0x%0h", name, val);
    endtask

    task automatic exp_mem(input logic [63:0] a, input logic w, input logic [63:0] d);
        mem_exp_t e;
        e.addr = a; e.wr = w; e.dout = d;
        mem_q.push_back(e);
    endtask

    task automatic exp_cpl(input logic [N-1:0] r, input logic [63:0] d);
        cpl_exp_t e;
        e.rdy = r; e.rdata = d;
        cpl_q.push_back(e);
    endtask

    // Memory model: rdy after mem_lat cycles of mem_req; read data = addr + 0xDE9D.
    initial begin
        int cnt;
        cnt = 0;
        mem_rdy = 1'b0;
        mem_din = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_rdy) begin
                mem_rdy = 1'b0;
                cnt = 0;
            end else if (mem_req && !rst) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    mem_rdy = 1'b1;
                    mem_din = mem_addr + 64'hDE9D;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        logic         req_q;
        logic [N-1:0] rdy_q;
        mem_exp_t     cur;
        cpl_exp_t     ce;
        req_q = 1'b0;
        rdy_q = '0;
        cur.addr = '0; cur.wr = 1'b0; cur.dout = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                req_q = 1'b0;
                rdy_q = '0;
            end else begin
                if (mem_req && !req_q) begin
                    $display("mem op: wr=%0b addr=0x%0h dout=0x%0h", mem_wr, mem_addr, mem_dout);
                    if (mem_q.size() == 0) begin
                        fail_now("mem_unexpected", mem_addr);
                    end else begin
                        cur = mem_q.pop_front();
                        check("mem_addr", mem_addr, cur.addr);
                        check("mem_wr", {63'd0, mem_wr}, {63'd0, cur.wr});
                        if (cur.wr) check("mem_dout", mem_dout, cur.dout);
                    end
                end else if (mem_req && mem_rdy) begin
                    check("mem_addr_hold", mem_addr, cur.addr);
                end
                if (cl_rdy != '0) begin
                    $display("completion: cl_rdy=%b cl_rdata=0x%0h", cl_rdy, cl_rdata);
                    check("rdy_single_pulse", {60'd0, rdy_q}, 64'd0);
                    if (cpl_q.size() == 0) begin
                        fail_now("cpl_unexpected", {60'd0, cl_rdy});
                    end else begin
                        ce = cpl_q.pop_front();
                        check("cl_rdy", {60'd0, cl_rdy}, {60'd0, ce.rdy});
                        check("cl_rdata", cl_rdata, ce.rdata);
                    end
                end
                req_q = mem_req;
                rdy_q = cl_rdy;
            end
        end
    end

    // Drive one requester transaction; entered and left at posedge+1.
    task automatic do_req(input int i, input logic w, input logic lk,
                          input logic [63:0] a, input logic [63:0] d, input int hold);
        int t;
        cl_wr[i] = w;
        cl_lock[i] = lk;
        cl_addr[i*AW +: AW] = a;
        cl_wdata[i*DW +: DW] = d;
        cl_req[i] = 1'b1;
        t = 0;
        do begin
            @(posedge clk); #1;
            t++;
        end while (!cl_rdy[i] && t < 200);
        if (!cl_rdy[i]) fail_now("req_timeout", i);
        repeat (hold) begin @(posedge clk); #1; end
        cl_req[i] = 1'b0;
    endtask

    task automatic do_reset();
        cl_req = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mem_req", {63'd0, mem_req}, 64'd0);
        check("rst_mem_wr", {63'd0, mem_wr}, 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_mem_dout", mem_dout, 64'd0);
        check("rst_cl_rdy", {60'd0, cl_rdy}, 64'd0);
        check("rst_cl_rdata", cl_rdata, 64'd0);
        check("rst_tmo_err", {63'd0, tmo_err}, 64'd0);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: value 0x0");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        rst = 1'b1;
        cl_req = '0; cl_wr = '0; cl_lock = '0; cl_addr = '0; cl_wdata = '0;
        @(posedge clk); #1;
        do_reset();

        // Single read, memory answers after 2 cycles
        mem_lat = 2;
        exp_mem(64'h10, 1'b0, 64'h0);
        exp_cpl(4'b0001, 64'hDEAD);
        do_req(0, 1'b0, 1'b0, 64'h10, 64'h0, 0);
        repeat (4) begin @(posedge clk); #1; end

        // All four writing continuously, 1-cycle memory: order 0,1,2,3,0,1,2,3
        do_reset();
        mem_lat = 1;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < N; i++) begin
                exp_mem(64'h100 + 64'(i*16 + k), 1'b1, 64'hA000 + 64'(i*16 + k));
                exp_cpl(4'(1 << i), 64'h0);
            end
        fork
            begin for (int k = 0; k < 2; k++) do_req(0, 1'b1, 1'b0, 64'h100 + 64'(k), 64'hA000 + 64'(k), 0); end
            begin for (int k = 0; k < 2; k++) do_req(1, 1'b1, 1'b0, 64'h110 + 64'(k), 64'hA010 + 64'(k), 0); end
            begin for (int k = 0; k < 2; k++) do_req(2, 1'b1, 1'b0, 64'h120 + 64'(k), 64'hA020 + 64'(k), 0); end
            begin for (int k = 0; k < 2; k++) do_req(3, 1'b1, 1'b0, 64'h130 + 64'(k), 64'hA030 + 64'(k), 0); end
        join
        repeat (3) begin @(posedge clk); #1; end
        check("no_tmo_normal", {63'd0, tmo_err}, 64'd0);

        // Lock RMW: req1 read+write back-to-back while req0/req2 pend
        do_reset();
        exp_mem(64'h20, 1'b0, 64'h0);        exp_cpl(4'b0001, 64'hDEBD);
        do_req(0, 1'b0, 1'b0, 64'h20, 64'h0, 0);
        exp_mem(64'h1FFF, 1'b0, 64'h0);      exp_cpl(4'b0010, 64'hFE9C);
        exp_mem(64'h1FFF, 1'b1, 64'hFE9D);   exp_cpl(4'b0010, 64'hFE9C);
        exp_mem(64'h40, 1'b1, 64'h4444);     exp_cpl(4'b0100, 64'hFE9C);
        exp_mem(64'h30, 1'b1, 64'h3333);     exp_cpl(4'b0001, 64'hFE9C);
        fork
            begin
                do_req(1, 1'b0, 1'b1, 64'h1FFF, 64'h0, 0);
                do_req(1, 1'b1, 1'b0, 64'h1FFF, 64'hFE9D, 0);
            end
            do_req(0, 1'b1, 1'b0, 64'h30, 64'h3333, 0);
            do_req(2, 1'b1, 1'b0, 64'h40, 64'h4444, 0);
        join
        repeat (3) begin @(posedge clk); #1; end

        // req3 rises during req0's DONE; req0 held one extra cycle
        do_reset();
        exp_mem(64'h50, 1'b0, 64'h0);    exp_cpl(4'b0001, 64'hDEED);
        exp_mem(64'h60, 1'b1, 64'hC0DE); exp_cpl(4'b1000, 64'hDEED);
        fork
            do_req(0, 1'b0, 1'b0, 64'h50, 64'h0, 1);
            begin
                automatic int t = 0;
                while (!cl_rdy[0] && t < 50) begin @(posedge clk); #1; t++; end
                do_req(3, 1'b1, 1'b0, 64'h60, 64'hC0DE, 0);
            end
        join
        repeat (4) begin @(posedge clk); #1; end

        // Reset while an op is pending in ISSUE; afterwards req0 beats req3
        do_reset();
        mem_lat = 10;
        exp_mem(64'h70, 1'b0, 64'h0);
        cl_wr[2] = 1'b0; cl_lock[2] = 1'b0; cl_addr[2*AW +: AW] = 64'h70; cl_req[2] = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        check("issue_pending", {63'd0, mem_req}, 64'd1);
        do_reset();
        mem_lat = 1;
        exp_mem(64'h90, 1'b0, 64'h0);    exp_cpl(4'b0001, 64'hDF2D);
        exp_mem(64'hA0, 1'b1, 64'hB0);   exp_cpl(4'b1000, 64'hDF2D);
        fork
            do_req(0, 1'b0, 1'b0, 64'h90, 64'h0, 0);
            do_req(3, 1'b1, 1'b0, 64'hA0, 64'hB0, 0);
        join
        repeat (3) begin @(posedge clk); #1; end

        // Watchdog with TMO_W = 4: rdy withheld 20 cycles
        do_reset();
        mem_lat = 20;
        exp_mem(64'h80, 1'b0, 64'h0);
        exp_cpl(4'b0010, 64'hDF1D);
        fork
            do_req(1, 1'b0, 1'b0, 64'h80, 64'h0, 0);
            begin
                automatic int t = 0;
                automatic int n = 0;
                while (!mem_req && t < 20) begin @(posedge clk); #1; t++; end
                while (!tmo_err && n < 40) begin @(posedge clk); #1; n++; end
                check("tmo_latency", 64'(n), 64'd15);
            end
        join
        check("tmo_after_cpl", {63'd0, tmo_err}, 64'd1);
        repeat (5) begin @(posedge clk); #1; end
        check("tmo_sticky", {63'd0, tmo_err}, 64'd1);

        check("mem_q_drained", 64'(mem_q.size()), 64'd0);
        check("cpl_q_drained", 64'(cpl_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
